// File: rtl/switch_pkg.sv
// Shared defaults and width helper for the switch input conditioner.
package switch_pkg;

  localparam int unsigned DefWidth   = 8;
  localparam int unsigned DefTickDiv = 1000;
  localparam int unsigned DefDbTicks = 4;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((64'd1 << w) < 64'(n)) begin
      w++;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/switch_input_conditioner_if.sv
// Switch-side bundle: raw levels and enable in, debounced data and strobes out.
interface switch_input_conditioner_if
  import switch_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) ();

  logic             ena;
  logic [WIDTH-1:0] sw_in;
  logic [WIDTH-1:0] data;
  logic             data_changed;
  logic [WIDTH-1:0] rising;

  modport master (
    output ena,
    output sw_in,
    input  data,
    input  data_changed,
    input  rising
  );

  modport slave (
    input  ena,
    input  sw_in,
    output data,
    output data_changed,
    output rising
  );

endinterface

// File: rtl/debounce_bit.sv
// One switch bit: 2-FF synchroniser, tick-qualified debounce counter and level flop.
module debounce_bit
  import switch_pkg::*;
#(
  parameter int unsigned DB_TICKS = DefDbTicks
) (
  input  logic clk,
  input  logic rst,
  input  logic ena_i,
  input  logic tick_i,
  input  logic raw_i,
  output logic level_o,
  output logic update_o
);

  localparam int unsigned CntW = clog2_min1(DB_TICKS);
  localparam logic [CntW-1:0] CntLast = CntW'(DB_TICKS - 1);

  logic            s1_q, s2_q;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            differ;
  logic            accept;

  // Synchroniser free-runs so the level is current the moment ena returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
    end
  end

  always_comb begin
    differ  = s2_q ^ level_q;
    accept  = ena_i & tick_i & differ & (cnt_q == CntLast);
    cnt_d   = cnt_q;
    level_d = level_q;
    if (ena_i) begin
      if (!differ) begin
        cnt_d = '0;
      end else if (tick_i) begin
        if (cnt_q == CntLast) begin
          level_d = s2_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o  = level_q;
  assign update_o = accept;

endmodule

// File: rtl/switch_input_conditioner.sv
// Synchronises and debounces WIDTH switch inputs; emits stable data plus change/rise strobes.
module switch_input_conditioner
  import switch_pkg::*;
#(
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned TICK_DIV = DefTickDiv,
  parameter int unsigned DB_TICKS = DefDbTicks
) (
  input  logic                       clk,
  input  logic                       rst,
  switch_input_conditioner_if.slave  bus
);

  localparam int unsigned PcW = clog2_min1(TICK_DIV);
  localparam logic [PcW-1:0] PcLast = PcW'(TICK_DIV - 1);

  logic [PcW-1:0]   pc_q, pc_d;
  logic             tick;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] update;
  logic             chg_q, chg_d;
  logic [WIDTH-1:0] rise_q, rise_d;

  always_comb begin
    tick = bus.ena && (pc_q == PcLast);
    pc_d = pc_q;
    if (bus.ena) begin
      pc_d = tick ? '0 : pc_q + PcW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bits
    debounce_bit #(
      .DB_TICKS (DB_TICKS)
    ) u_bit (
      .clk      (clk),
      .rst      (rst),
      .ena_i    (bus.ena),
      .tick_i   (tick),
      .raw_i    (bus.sw_in[i]),
      .level_o  (level[i]),
      .update_o (update[i])
    );
  end

  // update is only ever high with ena=1, so the strobes fall to 0 whenever ena is low.
  // A bit that updates while currently 0 is the one going 0->1.
  always_comb begin
    chg_d  = |update;
    rise_d = update & ~level;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chg_q  <= 1'b0;
      rise_q <= '0;
    end else begin
      chg_q  <= chg_d;
      rise_q <= rise_d;
    end
  end

  assign bus.data         = level;
  assign bus.data_changed = chg_q;
  assign bus.rising       = rise_q;

endmodule
